// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - register-file readout engine streaming {address, value} pairs
// Stalls the core, walks a latched address range through the read port and emits one word per handshake.
module reg_dump #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [D-1:0] lo_addr_i,
    input  logic [D-1:0] hi_addr_i,
    output logic         hold_cpu_o,
    output logic [D-1:0] rf_raddr_o,
    input  logic [W-1:0] rf_rdata_i,
    output logic [W-1:0] out_data_o,
    output logic [D-1:0] out_addr_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         out_last_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [D-1:0]   idx_q, idx_d;
    logic [D-1:0]   rem_q, rem_d;
    logic [W-1:0]   data_q, data_d;
    logic [D-1:0]   addr_q, addr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        data_d  = data_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SETTLE;
                    idx_d   = lo_addr_i;
                    // Modular difference: hi below lo wraps through the top of the file.
                    rem_d   = hi_addr_i - lo_addr_i;
                end
            end
            S_SETTLE: begin
                data_d  = rf_rdata_i;
                addr_d  = idx_q;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_ready_i) begin
                    if (rem_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + D'(1);
                        rem_d   = rem_q - D'(1);
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort wins over every transition out of a busy state, including a same-cycle handshake.
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    assign hold_cpu_o  = (state_q != S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign rf_raddr_o  = idx_q;
    assign out_data_o  = data_q;
    assign out_addr_o  = addr_q;
    assign out_valid_o = (state_q == S_SEND);
    assign out_last_o  = (state_q == S_SEND) && (rem_q == '0);
    assign done_o      = (state_q == S_DONE);

endmodule
